// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the UART transmit path. Holds the
//               frame shifter FSM state encoding, the ParityType codes, the
//               default data width and a parity-enable decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Frame shifter FSM states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_END    = 3'd4;

    // ParityType codes (both 00 and 11 mean "no parity bit")
    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    // True when the frame carries a parity bit slot
    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_shifter.sv
// ============================================================================
// Module      : uart_tx_frame_shifter
// Description : UART transmit frame builder. Accepts a data byte plus the
//               parity bit from the upstream parity unit and serialises
//               start, DATA_WIDTH data bits (LSB first), optional parity and
//               one or two stop bits onto TxOut, one bit per BaudTick.
// Ports       : clk        - system clock, rising edge
//               ResetN     - asynchronous active-low reset
//               BaudTick   - one-clk bit-period enable
//               Send       - frame request (sampled on BaudTick)
//               DataIn     - data word, latched on accept
//               ParityBit  - parity bit for DataIn, latched on accept
//               ParityType - 00/11 none, 01 odd, 10 even; latched on accept
//               StopBits   - 0 one stop bit, 1 two stop bits; latched
//               TxOut      - serial line, idles high
//               Busy       - frame in progress
//               Done       - one-clk pulse at frame completion
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame_shifter
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  ResetN,
    input  logic                  BaudTick,
    input  logic                  Send,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  ParityBit,
    input  logic [1:0]            ParityType,
    input  logic                  StopBits,
    output logic                  TxOut,
    output logic                  Busy,
    output logic                  Done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]            r_state;
    logic                  r_tx;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_parbit;
    logic [1:0]            r_ptype;
    logic                  r_stop2;

    logic                  w_accept;
    logic                  w_last_bit;

    // A new frame may start from IDLE, or from END for back-to-back frames
    assign w_accept   = BaudTick && Send &&
                        ((r_state == ST_IDLE) || (r_state == ST_END));
    assign w_last_bit = (r_cnt == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state  <= ST_IDLE;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_parbit <= 1'b0;
            r_ptype  <= PAR_NONE;
            r_stop2  <= 1'b0;
        end else begin
            // Done is only ever a single-clk pulse on the END tick
            r_done <= BaudTick && (r_state == ST_END);

            if (w_accept) begin
                r_shreg  <= DataIn;
                r_parbit <= ParityBit;
                r_ptype  <= ParityType;
                r_stop2  <= StopBits;
                r_tx     <= 1'b0;
                r_cnt    <= '0;
                r_state  <= ST_DATA;
            end else if (BaudTick) begin
                case (r_state)
                    ST_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    ST_DATA: begin
                        r_tx    <= r_shreg[0];
                        r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
                        if (w_last_bit) begin
                            r_cnt   <= '0;
                            r_state <= parity_enabled(r_ptype) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        r_tx    <= r_parbit;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_tx <= 1'b1;
                        // Counter is zero on entry; it marks the first of two stop bits
                        if (r_stop2 && (r_cnt == '0)) begin
                            r_cnt <= CNT_W'(1);
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_END;
                        end
                    end
                    ST_END: begin
                        r_tx    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign TxOut = r_tx;
    assign Busy  = (r_state != ST_IDLE);
    assign Done  = r_done;

endmodule

`default_nettype wire

// File: doc/uart_tx_frame_shifter.md
Name: uart_tx_frame_shifter

Overview:
- Transmit-side parallel-in/serial-out frame builder for the UART Tx path.
- Sits directly downstream of the Tx parity unit. It takes the data byte plus the parity bit that unit computes from the same byte, and serialises a full frame onto the Tx line: start, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
- Advances one bit per BaudTick, supplied by the external baud generator.

Parameters:
DATA_WIDTH, 8, data bits per frame; also sets the bit-counter width, $clog2(DATA_WIDTH).

Ports:
clk  input  1  system clock; all state updates on rising edge
ResetN  input  1  reset, asynchronous, active-low
BaudTick  input  1  one-clk-wide enable, one per bit period; all FSM/shift activity qualified by it
Send  input  1  frame request; sampled only on cycles with BaudTick=1
DataIn  input  DATA_WIDTH  byte to transmit; latched on accept
ParityBit  input  1  parity bit from the parity unit for the current DataIn; latched on accept
ParityType  input  2  00/11 = no parity, 01 = odd, 10 = even; latched on accept
StopBits  input  1  0 = one stop bit, 1 = two stop bits; latched on accept
TxOut  output  1  serial line, idles high
Busy  output  1  high while a frame is in progress (state != IDLE)
Done  output  1  one-clk pulse when a frame completes

Behaviour:
- Reset (async, ResetN=0): state IDLE, TxOut=1, Busy=0, Done=0, shift register, bit counter and latched config cleared. A reset mid-frame aborts the frame immediately and the line returns high with no Done.
- Nothing changes on cycles with BaudTick=0, except that Done clears on the cycle after it pulses.
- States:
  - IDLE:
    - TxOut=1.
    - On BaudTick with Send=1, accept: latch DataIn, ParityBit, ParityType and StopBits; set TxOut←0 (start bit); clear the counter; go to DATA.
  - DATA:
    - Each BaudTick: TxOut←shreg[0]; shift right; counter++.
    - After DATA_WIDTH bits: go to PARITY if the latched ParityType is 01 or 10, otherwise go to STOP.
  - PARITY: next BaudTick, TxOut←latched ParityBit; go to STOP.
  - STOP:
    - Each BaudTick, TxOut←1.
    - Stay 1 tick, or 2 ticks if latched StopBits=1.
    - Then go to END.
  - END:
    - Next BaudTick: Done←1 for one clk and Busy←0.
    - If Send=1 on that same tick, a new frame is accepted at once (back-to-back: TxOut←0, go to DATA, Done still pulses). Otherwise go to IDLE with TxOut=1.
- Tick numbering: the accept tick is T0.
  - Frame length is 1+DATA_WIDTH+P+S ticks, where P is 0 or 1 and S is 1 or 2.
  - Done fires on tick T(1+DATA_WIDTH+P+S).
- Busy rises on the clk following the accept tick.
- Send is ignored while Busy=1, except on the END tick.
- DataIn, ParityBit, ParityType and StopBits may change freely after accept; the frame uses the latched values.
- The parity unit is combinational, so ParityBit must be valid in the same cycle as DataIn at accept.

Decomposition:
- Shared package uart_tx_pkg holds:
  - FSM state encoding: IDLE, DATA, PARITY, STOP, END.
  - ParityType codes: PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE2=2'b11.
  - UART_DATA_WIDTH=8.
- No sub-module: the counter and shift register stay inline. The baud generator and parity unit remain separate sibling blocks.

Test Plan:
- Odd parity, one stop: DataIn=8'hA5, ParityType=01, ParityBit=1, StopBits=0, Send at T0.
  - TxOut over T0..T10 = 0,1,0,1,0,0,1,0,1,1,1.
  - Done pulses at T11; Busy high from T0+1clk through T11.
- No parity, two stops: DataIn=8'h3C, ParityType=00, StopBits=1.
  - TxOut = 0,0,0,1,1,1,1,0,0,1,1.
  - Done at T11; ParityBit value has no effect.
- Back-to-back: Send held high with DataIn=8'h00, even parity (ParityBit=0), one stop.
  - Second start bit (TxOut=0) appears on the END tick T11.
  - Done pulses once at T11; no idle bit between frames.
- Ignore while busy: assert Send with DataIn=8'hFF at T4 of a frame for 8'h55.
  - Frame continues to carry 8'h55.
  - Line idles after Done and no second frame starts.
- Reset mid-frame: drop ResetN at T5.
  - TxOut=1, Busy=0 and Done=0 asynchronously.
  - After release, a new Send with 8'h81 produces a clean full frame.
- Ticks gated: hold BaudTick low for 20 clks mid-DATA.
  - TxOut, Busy and the counter stay frozen.
  - Frame resumes correctly on the next tick.
